// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter: shares the single instruction-memory port between CPU fetch
// and a program loader; LOAD holds the CPU in reset, FLUSH restarts it from PC 0.
module imem_load_arbiter #(
  parameter int          DEPTH = 64,
  parameter int          CW    = $clog2(DEPTH) + 1,
  parameter logic [31:0] NOP   = 32'hE1A00000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic          cpu_stall,
  output logic          cpu_reset,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  input  logic          ld_done,
  output logic [CW-1:0] ld_count,
  output logic          ld_err,
  output logic [31:0]   mem_a,
  output logic [31:0]   mem_wd,
  output logic          mem_we,
  input  logic [31:0]   mem_rd
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [29:0]   DEPTH_W = 30'(DEPTH);

  // A loader write lands only on a word-aligned address inside the memory.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:2] < DEPTH_W);
  endfunction

  state_t        state_r;
  state_t        state_s;
  logic          accept_s;
  logic          wr_ok_s;
  logic [CW-1:0] count_r;
  logic          err_r;

  // State register; reset drops straight back to RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and port steering for each ownership phase.
  always_comb begin
    state_s   = state_r;
    instr     = mem_rd;
    mem_a     = pc;
    mem_wd    = ld_data;
    mem_we    = 1'b0;
    ld_ready  = 1'b0;
    cpu_stall = 1'b0;
    accept_s  = 1'b0;
    wr_ok_s   = addr_ok(ld_addr);
    case (state_r)
      ST_RUN: begin
        if (ld_start) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_LOAD: begin
        instr     = NOP;
        mem_a     = ld_addr;
        ld_ready  = 1'b1;
        cpu_stall = 1'b1;
        accept_s  = ld_valid;
        mem_we    = ld_valid & wr_ok_s;
        // The word presented alongside ld_done is still written.
        if (ld_done) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        instr     = NOP;
        cpu_stall = 1'b1;
        state_s   = ST_RUN;
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // Session statistics: cleared on session start, held through RUN afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
      err_r   <= 1'b0;
    end else if ((state_r == ST_RUN) && ld_start) begin
      count_r <= '0;
      err_r   <= 1'b0;
    end else if (accept_s && wr_ok_s) begin
      if (count_r != CNT_MAX) begin
        count_r <= count_r + CW'(1);
      end else begin
        count_r <= count_r;
      end
    end else if (accept_s) begin
      err_r <= 1'b1;
    end else begin
      count_r <= count_r;
      err_r   <= err_r;
    end
  end

  assign cpu_reset = reset | (state_r != ST_RUN);
  assign ld_count  = count_r;
  assign ld_err    = err_r;

endmodule
